rld_top: RTL and testbench
==========================

RLD_TOP -- requirements
Module: rld_top

Interface
REQ-001 Parameter ROW_W, default 32: pixels per image row; NR row-end marker period.
REQ-002 Parameter CNT_W, default 8: run-count field width, code[15:8].
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 start  input  3  one-cycle pulse per channel, bit0=R, bit1=G, bit2=B; loads the channel's code.
REQ-006 R_code, G_code, B_code  input  16 each  run code: [15:8] run count, [7:0] pixel value.
REQ-007 R, G, B  output  8 each  decoded pixel value per channel.
REQ-008 valid  output  3  per-channel flag: the pixel output is valid this cycle.
REQ-009 NR  output  3  per-channel new-row flag: the current valid pixel is the last pixel of a row.
REQ-010 done  output  3  per-channel sticky end-of-stream flag.

Function
REQ-011 The three channels SHALL be fully independent, identical decoders; bit i of each vector belongs to channel i.
REQ-012 Each channel SHALL have an FSM with states IDLE, RUN and DONE.
REQ-013 IDLE + start=1 + count≠0: SHALL latch the value and count, and enter RUN on the next edge.
REQ-014 IDLE + start=1 + count=0: SHALL enter DONE; code 0x0000 (any value byte) is the end-of-stream marker.
REQ-015 RUN: each cycle, valid=1 and pixel=latched value (registered outputs); the remaining count SHALL decrement; the channel SHALL return to IDLE after exactly count valid cycles.
REQ-016 Latency: the first valid pixel SHALL appear on the cycle after the start edge, i.e. at the second rising edge after start is sampled.
REQ-017 start while in RUN or DONE SHALL be ignored, and the code SHALL not be latched.
REQ-018 Column counter, range 0..ROW_W-1, SHALL advance on each valid pixel and persist across runs; NR=1 together with valid when the column is ROW_W-1, then the counter wraps to 0.
REQ-019 NR SHALL never be 1 while valid=0.
REQ-020 DONE SHALL hold done=1, valid=0 and NR=0 until reset.
REQ-021 IDLE: valid=0 and NR=0; the pixel output SHALL hold its last value.
REQ-022 Count arithmetic is unsigned CNT_W bits; a count of 255 SHALL yield 255 pixels.

Reset
REQ-023 rst SHALL force, on the next edge, all channels to IDLE, the column counter to 0, and R=G=B=0, valid=0, NR=0, done=0.
REQ-024 rst asserted mid-RUN or in DONE SHALL abort the run and discard the remaining count.
REQ-025 rst has priority over start in the same cycle.

Structure
REQ-026 A shared package rld_pkg SHALL hold the state enum (IDLE/RUN/DONE), code field positions (CNT_MSB=15, CNT_LSB=8, VAL_MSB=7, VAL_LSB=0) and the end-marker constant.
REQ-027 A sub-module rld_channel (one decoder plus column counter) SHALL be instantiated three times by rld_top.

Verification
REQ-028 R_code=0x0305, start[0] pulse -> R=5 with valid[0]=1 for exactly 3 cycles starting the cycle after the start edge; valid[0]=0 afterwards.
REQ-029 ROW_W=4; R codes 0x0201 then 0x0302 -> pixel sequence 1,1,2,2 with NR[0]=1 on the 4th pixel, then 2 with NR[0]=0.
REQ-030 R_code=0x0000 -> done[0]=1 one cycle later and held; a further start[0] with 0x0207 -> no valid pulses.
REQ-031 Simultaneous start=3'b111, R/G/B codes 0x0111/0x0222/0x0333 -> R=0x11 for 1 cycle, G=0x22 for 2 cycles, B=0x33 for 3 cycles; the channels do not interfere.
REQ-032 R_code=0x0A09, rst asserted on the 3rd valid cycle -> valid[0]=0 and R=0 on the next edge; a new start with 0x0104 -> a single pixel 4, column counter restarted at 0.
REQ-033 start[0] re-pulsed during the run of 0x0506 with code 0x0107 -> exactly 5 pixels of value 6, and 7 never appears.

Source files
------------

// File: rtl/rld_pkg.sv
// Shared definitions for the run-length pixel decoder: code field layout,
// channel FSM states and the end-of-stream marker.
package rld_pkg;

  localparam int unsigned CODE_W  = 16;
  localparam int unsigned VAL_W   = 8;
  localparam int unsigned CNT_MSB = 15;
  localparam int unsigned CNT_LSB = 8;
  localparam int unsigned VAL_MSB = 7;
  localparam int unsigned VAL_LSB = 0;

  // Only the count byte identifies the marker; the value byte is don't-care.
  localparam logic [CODE_W-1:0] END_MARKER = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_end_marker(input logic [CODE_W-1:0] code);
    return code[CNT_MSB:CNT_LSB] == END_MARKER[CNT_MSB:CNT_LSB];
  endfunction

  function automatic logic [VAL_W-1:0] code_value(input logic [CODE_W-1:0] code);
    return code[VAL_MSB:VAL_LSB];
  endfunction

endpackage

// File: rtl/rld_channel.sv
// One run-length decoder channel: IDLE/RUN/DONE FSM with registered pixel
// outputs and a row column counter that persists across runs.
module rld_channel
  import rld_pkg::*;
#(
  parameter int unsigned ROW_W = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CODE_W-1:0] code,
  output logic [VAL_W-1:0]  pixel,
  output logic              valid,
  output logic              nr,
  output logic              done
);

  localparam int unsigned COL_W = (ROW_W > 1) ? $clog2(ROW_W) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_W - 1);

  state_t             state;
  logic [CNT_W-1:0]   remaining;
  logic [VAL_W-1:0]   val_q;
  logic [COL_W-1:0]   col;
  logic [CNT_W-1:0]   code_cnt;

  assign code_cnt = CNT_W'(code[CNT_MSB:CNT_LSB]);

  // Decoder FSM; valid/nr default low every cycle and are only raised in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      val_q     <= '0;
      col       <= '0;
      pixel     <= '0;
      valid     <= 1'b0;
      nr        <= 1'b0;
      done      <= 1'b0;
    end else begin
      valid <= 1'b0;
      nr    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_end_marker(code)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              val_q     <= code_value(code);
              remaining <= code_cnt;
              state     <= RUN;
            end
          end
        end
        RUN: begin
          valid     <= 1'b1;
          pixel     <= val_q;
          nr        <= (col == COL_LAST);
          col       <= (col == COL_LAST) ? '0 : col + COL_W'(1);
          remaining <= remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            state <= IDLE;
          end
        end
        DONE: begin
          done <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/rld_top.sv
// Three independent run-length decoders for the R, G and B channels;
// bit i of start/valid/NR/done belongs to channel i (0=R, 1=G, 2=B).
module rld_top
  import rld_pkg::*;
#(
  parameter int unsigned ROW_W = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        start,
  input  logic [CODE_W-1:0] R_code,
  input  logic [CODE_W-1:0] G_code,
  input  logic [CODE_W-1:0] B_code,
  output logic [VAL_W-1:0]  R,
  output logic [VAL_W-1:0]  G,
  output logic [VAL_W-1:0]  B,
  output logic [2:0]        valid,
  output logic [2:0]        NR,
  output logic [2:0]        done
);

  rld_channel #(.ROW_W(ROW_W), .CNT_W(CNT_W)) u_r (
    .clk   (clk),
    .rst   (rst),
    .start (start[0]),
    .code  (R_code),
    .pixel (R),
    .valid (valid[0]),
    .nr    (NR[0]),
    .done  (done[0])
  );

  rld_channel #(.ROW_W(ROW_W), .CNT_W(CNT_W)) u_g (
    .clk   (clk),
    .rst   (rst),
    .start (start[1]),
    .code  (G_code),
    .pixel (G),
    .valid (valid[1]),
    .nr    (NR[1]),
    .done  (done[1])
  );

  rld_channel #(.ROW_W(ROW_W), .CNT_W(CNT_W)) u_b (
    .clk   (clk),
    .rst   (rst),
    .start (start[2]),
    .code  (B_code),
    .pixel (B),
    .valid (valid[2]),
    .nr    (NR[2]),
    .done  (done[2])
  );

endmodule

// File: tb/tb_rld_top.sv
// Directed bench for rld_top with ROW_W=4: per-cycle vector table plus
// hand-written sequences for reset abort, ignored restarts and a 255 run.
module tb_rld_top;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  start;
  logic [15:0] R_code, G_code, B_code;
  logic [7:0]  R, G, B;
  logic [2:0]  valid, NR, done;

  int checks = 0;
  int failures = 0;

  rld_top #(.ROW_W(4), .CNT_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .R_code (R_code),
    .G_code (G_code),
    .B_code (B_code),
    .R      (R),
    .G      (G),
    .B      (B),
    .valid  (valid),
    .NR     (NR),
    .done   (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [2:0]  start;
    logic [15:0] rc, gc, bc;
    logic [7:0]  r, g, b;
    logic [2:0]  valid, nr, done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rs, logic [2:0] st, logic [15:0] rc, logic [15:0] gc,
                              logic [15:0] bc, logic [7:0] r, logic [7:0] g, logic [7:0] b,
                              logic [2:0] v, logic [2:0] n, logic [2:0] d);
    vec_t x;
    x.rst = rs; x.start = st; x.rc = rc; x.gc = gc; x.bc = bc;
    x.r = r; x.g = g; x.b = b; x.valid = v; x.nr = n; x.done = d;
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rs, input logic [2:0] st, input logic [15:0] rc,
                       input logic [15:0] gc, input logic [15:0] bc);
    rst = rs; start = st; R_code = rc; G_code = gc; B_code = bc;
  endtask

  // Apply current inputs at one rising edge, then settle past it for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 3'b000, 16'h0, 16'h0, 16'h0);
  endtask

  int nv, bad, nr_bad, col;
  logic [2:0] nr_seq;

  initial begin
    drive(1'b1, 3'b000, 16'h0, 16'h0, 16'h0);

    //        rst  start   R_code    G_code    B_code    R      G      B      valid   NR      done
    vecs.push_back(mk(1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 8'h00, 8'h00, 8'h00, 3'b000, 3'b000, 3'b000));
    vecs.push_back(mk(0, 3'b001, 16'h0305, 16'h0000, 16'h0000, 8'h00, 8'h00, 8'h00, 3'b000, 3'b000, 3'b000));
    vecs.push_back(mk(0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 8'h05, 8'h00, 8'h00, 3'b001, 3'b000, 3'b000));
    vecs.push_back(mk(0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 8'h05, 8'h00, 8'h00, 3'b001, 3'b000, 3'b000));
    vecs.push_back(mk(0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 8'h05, 8'h00, 8'h00, 3'b001, 3'b000, 3'b000));
    vecs.push_back(mk(0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 8'h05, 8'h00, 8'h00, 3'b000, 3'b000, 3'b000));
    // row-end marker across two runs
    vecs.push_back(mk(1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 8'h00, 8'h00, 8'h00, 3'b000, 3'b000, 3'b000));
    vecs.push_back(mk(0, 3'b001, 16'h0201, 16'h0000, 16'h0000, 8'h00, 8'h00, 8'h00, 3'b000, 3'b000, 3'b000));
    vecs.push_back(mk(0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 8'h01, 8'h00, 8'h00, 3'b001, 3'b000, 3'b000));
    vecs.push_back(mk(0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 8'h01, 8'h00, 8'h00, 3'b001, 3'b000, 3'b000));
    vecs.push_back(mk(0, 3'b001, 16'h0302, 16'h0000, 16'h0000, 8'h01, 8'h00, 8'h00, 3'b000, 3'b000, 3'b000));
    vecs.push_back(mk(0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 8'h02, 8'h00, 8'h00, 3'b001, 3'b000, 3'b000));
    vecs.push_back(mk(0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 8'h02, 8'h00, 8'h00, 3'b001, 3'b001, 3'b000));
    vecs.push_back(mk(0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 8'h02, 8'h00, 8'h00, 3'b001, 3'b000, 3'b000));
    vecs.push_back(mk(0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 8'h02, 8'h00, 8'h00, 3'b000, 3'b000, 3'b000));
    // three channels started together
    vecs.push_back(mk(1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 8'h00, 8'h00, 8'h00, 3'b000, 3'b000, 3'b000));
    vecs.push_back(mk(0, 3'b111, 16'h0111, 16'h0222, 16'h0333, 8'h00, 8'h00, 8'h00, 3'b000, 3'b000, 3'b000));
    vecs.push_back(mk(0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 8'h11, 8'h22, 8'h33, 3'b111, 3'b000, 3'b000));
    vecs.push_back(mk(0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 8'h11, 8'h22, 8'h33, 3'b110, 3'b000, 3'b000));
    vecs.push_back(mk(0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 8'h11, 8'h22, 8'h33, 3'b100, 3'b000, 3'b000));
    vecs.push_back(mk(0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 8'h11, 8'h22, 8'h33, 3'b000, 3'b000, 3'b000));
    // end marker on R; G keeps decoding while R ignores its start
    vecs.push_back(mk(0, 3'b001, 16'h0000, 16'h0000, 16'h0000, 8'h11, 8'h22, 8'h33, 3'b000, 3'b000, 3'b001));
    vecs.push_back(mk(0, 3'b011, 16'h0207, 16'h0144, 16'h0000, 8'h11, 8'h22, 8'h33, 3'b000, 3'b000, 3'b001));
    vecs.push_back(mk(0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 8'h11, 8'h44, 8'h33, 3'b010, 3'b000, 3'b001));
    vecs.push_back(mk(0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 8'h11, 8'h44, 8'h33, 3'b000, 3'b000, 3'b001));
    // reset wins over a simultaneous start
    vecs.push_back(mk(1, 3'b001, 16'h0305, 16'h0000, 16'h0000, 8'h00, 8'h00, 8'h00, 3'b000, 3'b000, 3'b000));
    vecs.push_back(mk(0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 8'h00, 8'h00, 8'h00, 3'b000, 3'b000, 3'b000));
    vecs.push_back(mk(0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 8'h00, 8'h00, 8'h00, 3'b000, 3'b000, 3'b000));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].start, vecs[i].rc, vecs[i].gc, vecs[i].bc);
      tick();
      check($sformatf("vec%0d", i),
            64'({R, G, B, valid, NR, done}),
            64'({vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].valid, vecs[i].nr, vecs[i].done}));
    end

    // Reset on the third valid pixel of a 10-pixel run, then restart.
    drive(1'b1, 3'b000, 16'h0, 16'h0, 16'h0); tick();
    drive(1'b0, 3'b001, 16'h0A09, 16'h0, 16'h0); tick();
    nv = 0;
    for (int i = 0; i < 10 && nv < 3; i++) begin
      idle(); tick();
      if (valid[0]) nv++;
    end
    check("abort_reach_third", 64'(nv), 64'd3);
    drive(1'b1, 3'b000, 16'h0, 16'h0, 16'h0); tick();
    check("abort_outputs", 64'({valid[0], R, NR[0]}), 64'h0);
    idle(); tick();
    check("abort_discard", 64'(valid), 64'h0);
    drive(1'b0, 3'b001, 16'h0104, 16'h0, 16'h0); tick();
    idle(); tick();
    check("restart_pixel", 64'({R, valid, NR}), 64'({8'h04, 3'b001, 3'b000}));
    tick();
    check("restart_single", 64'(valid), 64'h0);
    // column restarted: pixel 4 took column 0, so this run covers columns 1..3
    drive(1'b0, 3'b001, 16'h0305, 16'h0, 16'h0); tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      nr_seq[i] = NR[0];
    end
    check("col_restart_nr", 64'(nr_seq), 64'(3'b100));

    // Restarts during a run are ignored.
    idle(); tick();
    drive(1'b0, 3'b001, 16'h0506, 16'h0, 16'h0); tick();
    nv = 0; bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 0 || i == 2) drive(1'b0, 3'b001, 16'h0107, 16'h0, 16'h0);
      else idle();
      tick();
      if (valid[0]) begin
        nv++;
        if (R != 8'h06) bad++;
      end
    end
    check("ignore_start_count", 64'(nv), 64'd5);
    check("ignore_start_value", 64'(bad), 64'd0);

    // Maximum count with column model for NR.
    drive(1'b1, 3'b000, 16'h0, 16'h0, 16'h0); tick();
    drive(1'b0, 3'b001, 16'hFF0A, 16'h0, 16'h0); tick();
    idle();
    nv = 0; bad = 0; nr_bad = 0; col = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (valid[0]) begin
        nv++;
        if (R != 8'h0A) bad++;
        if (NR[0] !== (col == 3)) nr_bad++;
        col = (col + 1) % 4;
      end else if (NR[0] !== 1'b0) begin
        nr_bad++;
      end
    end
    check("max_count", 64'(nv), 64'd255);
    check("max_value", 64'(bad), 64'd0);
    check("max_nr", 64'(nr_bad), 64'd0);
    check("max_idle_after", 64'({valid, done}), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
